ras_ckpt: RTL

Parametrised return-address stack with multi-slot checkpoint/restore, the successor to the single-rollback RAS in the fetch/prediction stage. Calls push a return address and returns pop it; the top entry drives jalr/ret target prediction. Up to CKPT_NUM in-flight branches each snapshot the stack state. A redirect restores any snapshot in one cycle, repairing pointer, occupancy and the top entry.

---
 rtl/ras_ckpt.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
// Return-address stack with multi-slot checkpoint/restore.
// Calls push a return address and returns pop it. The entry at the top pointer
// is the jalr/ret prediction target. Each checkpoint slot holds a snapshot of
// pointer, occupancy and top value. A restore brings back any snapshot in one
// cycle and also rewrites the top entry.
module ras_ckpt #(
  parameter int ADDR_W     = 32,
  parameter int DEPTH_LOG2 = 4,
  parameter int CKPT_ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [ADDR_W-1:0]    push_addr,
  input  logic                 pop,
  output logic [ADDR_W-1:0]    top_addr,
  output logic                 top_valid,
  input  logic                 ckpt_save,
  input  logic [CKPT_ID_W-1:0] ckpt_save_id,
  input  logic                 ckpt_restore,
  input  logic [CKPT_ID_W-1:0] ckpt_restore_id,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int CKPT_NUM = 1 << CKPT_ID_W;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);

  typedef struct packed {
    logic                  valid;
    logic [DEPTH_LOG2-1:0] ptr;
    logic [DEPTH_LOG2:0]   cnt;
    logic [ADDR_W-1:0]     top;
  } slot_t;

  logic [ADDR_W-1:0]     entry [DEPTH];
  logic [DEPTH_LOG2-1:0] ptr;
  logic [DEPTH_LOG2:0]   cnt;
  slot_t                 slot [CKPT_NUM];

  logic [DEPTH_LOG2-1:0] ptr_nxt;
  logic [DEPTH_LOG2:0]   cnt_nxt;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [ADDR_W-1:0]     wr_data;
  logic [ADDR_W-1:0]     top_nxt;
  logic                  ovf_nxt;
  logic                  unf_nxt;
  slot_t                 rd_slot;

  assign rd_slot   = slot[ckpt_restore_id];
  assign top_addr  = entry[ptr];
  assign top_valid = (cnt != '0);

  // Next pointer/occupancy and the single entry write for this cycle.
  // Restore wins over push/pop; those ops are wrong-path and are dropped.
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    wr_data = push_addr;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (ckpt_restore) begin
      wr_en = 1'b1;
      if (rd_slot.valid) begin
        ptr_nxt = rd_slot.ptr;
        cnt_nxt = rd_slot.cnt;
        wr_idx  = rd_slot.ptr;
        wr_data = rd_slot.top;
      end else begin
        // Never-saved slot: fall back to the reset state.
        ptr_nxt = '0;
        cnt_nxt = '0;
        wr_idx  = '0;
        wr_data = '0;
      end
    end else if (push && pop) begin
      // Coroutine jalr: replace the top in place.
      wr_en = 1'b1;
      if (cnt == '0) cnt_nxt = CNT_ONE;
    end else if (push) begin
      ptr_nxt = ptr + 1'b1;
      wr_en   = 1'b1;
      wr_idx  = ptr + 1'b1;
      if (cnt == CNT_FULL) ovf_nxt = 1'b1;
      else                 cnt_nxt = cnt + 1'b1;
    end else if (pop) begin
      if (cnt != '0) begin
        ptr_nxt = ptr - 1'b1;
        cnt_nxt = cnt - 1'b1;
      end else begin
        unf_nxt = 1'b1;
      end
    end
  end

  // Top value as it will be after this edge; a save captures it.
  always_comb begin
    top_nxt = entry[ptr_nxt];
    if (wr_en && (wr_idx == ptr_nxt)) top_nxt = wr_data;
  end

  // Stack storage, pointer and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) entry[wr_idx] <= wr_data;
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end

  // Checkpoint slots record the post-update state of this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CKPT_NUM; i++) slot[i] <= '0;
    end else if (ckpt_save) begin
      slot[ckpt_save_id] <= {1'b1, ptr_nxt, cnt_nxt, top_nxt};
    end
  end

  // Registered single-cycle overflow/underflow pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

endmodule
